// File: rtl/div_pkg.sv
// Shared types and defaults for the shared iterative divider scheduler.
package div_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ID_W    = $clog2(DEF_NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        RESP
    } state_t;

    // Response record laid out at the default widths.
    typedef struct packed {
        logic [DEF_ID_W-1:0]  id;
        logic [DEF_WIDTH-1:0] quotient;
        logic [DEF_WIDTH-1:0] remainder;
        logic                 div_by_zero;
        logic                 overflow;
    } rsp_t;

endpackage

// File: rtl/div_core.sv
// Unsigned radix-2 restoring divider: one quotient bit per cycle, WIDTH cycles per operation.
module div_core
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;

    // NOTE: every always_comb output gets a value on every path so no latch is inferred.
    always_comb begin
        trial = {remainder, quotient[WIDTH-1]};
        diff  = trial - {1'b0, divisor_q};
    end

    // The quotient register doubles as the dividend shifter; diff[WIDTH] is the borrow.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            divisor_q <= '0;
        end else if (start) begin
            busy      <= 1'b1;
            cnt       <= CNT_W'(WIDTH);
            quotient  <= dividend;
            remainder <= '0;
            divisor_q <= divisor;
        end else if (busy) begin
            if (diff[WIDTH]) begin
                remainder <= trial[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b0};
            end else begin
                remainder <= diff[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b1};
            end
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
                busy <= 1'b0;
            end
        end
    end

    assign done = busy && (cnt == CNT_W'(1));

endmodule

// File: rtl/div_scheduler.sv
// Round-robin front end sharing one signed divider among NUM_REQ requesters,
// with divide-by-zero and MIN/-1 answered without running the core.
module div_scheduler
    import div_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_dividend,
    input  logic [NUM_REQ*WIDTH-1:0] req_divisor,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_quotient,
    output logic [WIDTH-1:0]         rsp_remainder,
    output logic                     rsp_div_by_zero,
    output logic                     rsp_overflow
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state, state_next;
    logic [ID_W-1:0]  rr_ptr, grant_id, cand;
    logic             grant_found, req_fire;
    logic [WIDTH-1:0] sel_dividend, sel_divisor, mag_dividend, mag_divisor;
    logic             div_zero, overflow, quo_neg, rem_neg;
    logic             core_start, core_busy, core_done;
    logic [WIDTH-1:0] core_quotient, core_remainder;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    always_comb begin
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_dividend = req_dividend[i*WIDTH +: WIDTH];
                sel_divisor  = req_divisor[i*WIDTH +: WIDTH];
            end
        end
    end

    // Unsigned WIDTH-bit negation of MIN yields 2^(WIDTH-1), which is exactly |MIN|.
    assign mag_dividend = sel_dividend[WIDTH-1] ? (~sel_dividend + 1'b1) : sel_dividend;
    assign mag_divisor  = sel_divisor[WIDTH-1]  ? (~sel_divisor + 1'b1)  : sel_divisor;
    assign div_zero     = (sel_divisor == '0);
    assign overflow     = (sel_dividend == MIN_VAL) && (sel_divisor == '1);

    always_comb begin
        state_next = state;
        req_ready  = '0;
        core_start = 1'b0;
        case (state)
            IDLE: begin
                if (rst_n && grant_found) begin
                    req_ready[grant_id] = 1'b1;
                    core_start          = !(div_zero || overflow);
                    state_next          = (div_zero || overflow) ? RESP : CALC;
                end
            end
            CALC: begin
                if (core_done) begin
                    state_next = FIX;
                end else if (!core_busy) begin
                    state_next = IDLE;
                end
            end
            FIX:  state_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign req_fire  = |(req_valid & req_ready);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr          <= '0;
            rsp_id          <= '0;
            rsp_quotient    <= '0;
            rsp_remainder   <= '0;
            rsp_div_by_zero <= 1'b0;
            rsp_overflow    <= 1'b0;
            quo_neg         <= 1'b0;
            rem_neg         <= 1'b0;
        end else begin
            if (req_fire) begin
                rr_ptr          <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                rsp_id          <= grant_id;
                quo_neg         <= sel_dividend[WIDTH-1] ^ sel_divisor[WIDTH-1];
                rem_neg         <= sel_dividend[WIDTH-1];
                rsp_div_by_zero <= div_zero;
                rsp_overflow    <= overflow;
                if (div_zero) begin
                    rsp_quotient  <= '1;
                    rsp_remainder <= sel_dividend;
                end else if (overflow) begin
                    rsp_quotient  <= MIN_VAL;
                    rsp_remainder <= '0;
                end
            end
            if (state == FIX) begin
                rsp_quotient  <= quo_neg ? (~core_quotient + 1'b1) : core_quotient;
                rsp_remainder <= rem_neg ? (~core_remainder + 1'b1) : core_remainder;
            end
        end
    end

    div_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (core_start),
        .dividend  (mag_dividend),
        .divisor   (mag_divisor),
        .busy      (core_busy),
        .done      (core_done),
        .quotient  (core_quotient),
        .remainder (core_remainder)
    );

endmodule
